// File: rtl/mem_copy_engine.sv
// Block copy / fill engine driving one port of main memory.
// Copies src->dst (overlap-safe) or fills dst with a constant.
module mem_copy_engine #(
  parameter int ADDR      = 14,
  parameter int DATA      = 18,
  parameter int MEM_WORDS = 11264
) (
  input  logic            clka,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  input  logic [ADDR-1:0] src,
  input  logic [ADDR-1:0] dst,
  input  logic [ADDR-1:0] len,
  input  logic [DATA-1:0] fill_data,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [ADDR-1:0] mem_addr,
  output logic            mem_we,
  output logic [DATA-1:0] mem_din,
  input  logic [DATA-1:0] mem_dout
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_FILL = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [ADDR:0]   W_LIM = (ADDR+1)'(MEM_WORDS);
  localparam logic [ADDR-1:0] ONE   = ADDR'(1);

  logic [2:0]      r_state;
  logic [ADDR-1:0] r_src;
  logic [ADDR-1:0] r_dst;
  logic [ADDR-1:0] r_cnt;
  logic [DATA-1:0] r_fill;
  logic            r_desc;
  logic            r_err;

  logic [ADDR:0]   w_src_end;
  logic [ADDR:0]   w_dst_end;
  logic            w_rng_ok;
  logic            w_desc;
  logic            w_last;

  assign w_src_end = {1'b0, src} + {1'b0, len};
  assign w_dst_end = {1'b0, dst} + {1'b0, len};
  assign w_rng_ok  = mode ? (w_dst_end <= W_LIM)
                          : (w_dst_end <= W_LIM) &&
                            (w_src_end <= W_LIM);
  // dst inside (src, src+len) would overwrite unread source words
  assign w_desc    = (dst > src) && ({1'b0, dst} < w_src_end);
  assign w_last    = (r_cnt == ONE);

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_fill  <= '0;
      r_desc  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_fill <= fill_data;
            r_cnt  <= len;
            r_desc <= w_desc;
            r_src  <= w_desc ? src + len - ONE : src;
            r_dst  <= w_desc ? dst + len - ONE : dst;
            r_err  <= !w_rng_ok;
            if (!w_rng_ok || len == '0)
              r_state <= S_FIN;
            else
              r_state <= mode ? S_FILL : S_RD;
          end
        end
        S_RD: begin
          if (abort) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_state <= S_WR;
          end
        end
        S_WR: begin
          r_src <= r_desc ? r_src - ONE : r_src + ONE;
          r_dst <= r_desc ? r_dst - ONE : r_dst + ONE;
          r_cnt <= r_cnt - ONE;
          if (abort) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_state <= w_last ? S_FIN : S_RD;
          end
        end
        S_FILL: begin
          r_dst <= r_dst + ONE;
          r_cnt <= r_cnt - ONE;
          if (abort) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end else if (w_last) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_FIN);
  assign err    = done && r_err;
  assign mem_we = (r_state == S_WR) || (r_state == S_FILL);

  // read data is forwarded combinationally into the write
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    unique case (r_state)
      S_RD: mem_addr = r_src;
      S_WR: begin
        mem_addr = r_dst;
        mem_din  = mem_dout;
      end
      S_FILL: begin
        mem_addr = r_dst;
        mem_din  = r_fill;
      end
      default: begin
        mem_addr = '0;
        mem_din  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 1-cycle-latency memory model.
// Each comparison is an immediate assertion that counts failures.
module tb_mem_copy_engine;

  logic        clka = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [13:0] src;
  logic [13:0] dst;
  logic [13:0] len;
  logic [17:0] fill_data;
  logic        abort;
  logic        busy;
  logic        done;
  logic        err;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [17:0] mem_din;
  logic [17:0] mem_dout;

  logic [17:0] mem [0:11263];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cyc0  = 0;
  int wr_n  = 0;
  int ndone = 0;
  logic [13:0] first_addr;
  int dcyc;
  logic derr;

  mem_copy_engine dut (
    .clka(clka), .reset(reset), .start(start), .mode(mode),
    .src(src), .dst(dst), .len(len), .fill_data(fill_data),
    .abort(abort), .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clka = ~clka;

  always @(posedge clka) begin
    cyc <= cyc + 1;
    if (mem_we && mem_addr < 14'd11264)
      mem[mem_addr] <= mem_din;
    mem_dout <= (mem_addr < 14'd11264) ? mem[mem_addr] : 18'h0;
  end

  always @(negedge clka) begin
    if (mem_we) begin
      if (wr_n == 0) first_addr = mem_addr;
      wr_n++;
    end
    if (done) ndone++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic m, input logic [13:0] s,
                        input logic [13:0] d, input logic [13:0] l,
                        input logic [17:0] f);
    @(negedge clka);
    mode = m; src = s; dst = d; len = l; fill_data = f;
    wr_n = 0; ndone = 0;
    start = 1'b1;
    @(posedge clka);
    #1;
    cyc0  = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    dcyc = -1;
    derr = 1'bx;
    for (int n = 0; n < 200 && dcyc < 0; n++) begin
      @(negedge clka);
      if (done) begin
        dcyc = cyc - cyc0 + 1;
        derr = err;
      end
    end
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    @(negedge clka);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 11264; i++) mem[i] = 18'(i);
    mem[10] = 18'h3000A;
    mem[11] = 18'h3000B;
    mem[12] = 18'h3000C;
    mem[13] = 18'h3000D;
    reset = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    src = '0; dst = '0; len = '0; fill_data = '0;
    repeat (3) @(posedge clka);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_din", 32'(mem_din), 32'd0);
    @(negedge clka);
    reset = 1'b0;

    // 1: ascending copy
    launch(1'b0, 14'd100, 14'd2000, 14'd4, 18'h0);
    wait_done("t1");
    chk("t1_cycle", 32'(dcyc), 32'd9);
    chk("t1_err", 32'(derr), 32'd0);
    chk("t1_writes", 32'(wr_n), 32'd4);
    chk("t1_first", 32'(first_addr), 32'd2000);
    chk("t1_m0", 32'(mem[2000]), 32'd100);
    chk("t1_m3", 32'(mem[2003]), 32'd103);

    // 2: overlapping copy, dst above src
    launch(1'b0, 14'd10, 14'd12, 14'd4, 18'h0);
    wait_done("t2");
    chk("t2_cycle", 32'(dcyc), 32'd9);
    chk("t2_first", 32'(first_addr), 32'd15);
    chk("t2_m10", 32'(mem[10]), 32'h3000A);
    chk("t2_m11", 32'(mem[11]), 32'h3000B);
    chk("t2_m12", 32'(mem[12]), 32'h3000A);
    chk("t2_m13", 32'(mem[13]), 32'h3000B);
    chk("t2_m14", 32'(mem[14]), 32'h3000C);
    chk("t2_m15", 32'(mem[15]), 32'h3000D);

    // 3: fill at top of memory, then one past it
    launch(1'b1, 14'd0, 14'd11260, 14'd4, 18'h2A5A5);
    wait_done("t3a");
    chk("t3a_cycle", 32'(dcyc), 32'd5);
    chk("t3a_err", 32'(derr), 32'd0);
    chk("t3a_writes", 32'(wr_n), 32'd4);
    chk("t3a_m0", 32'(mem[11260]), 32'h2A5A5);
    chk("t3a_m3", 32'(mem[11263]), 32'h2A5A5);
    launch(1'b1, 14'd0, 14'd11261, 14'd4, 18'h1111);
    wait_done("t3b");
    chk("t3b_cycle", 32'(dcyc), 32'd1);
    chk("t3b_err", 32'(derr), 32'd1);
    chk("t3b_writes", 32'(wr_n), 32'd0);
    chk("t3b_m", 32'(mem[11261]), 32'h2A5A5);

    // 4: zero length, then start pulsed while busy
    launch(1'b0, 14'd5, 14'd6, 14'd0, 18'h0);
    wait_done("t4a");
    chk("t4a_cycle", 32'(dcyc), 32'd1);
    chk("t4a_err", 32'(derr), 32'd0);
    chk("t4a_writes", 32'(wr_n), 32'd0);
    launch(1'b1, 14'd0, 14'd3000, 14'd8, 18'h12345);
    @(negedge clka);
    mode = 1'b1; dst = 14'd4000; len = 14'd2; fill_data = 18'h0;
    start = 1'b1;
    @(posedge clka);
    #1 start = 1'b0;
    wait_done("t4b");
    chk("t4b_cycle", 32'(dcyc), 32'd9);
    chk("t4b_writes", 32'(wr_n), 32'd8);
    chk("t4b_m7", 32'(mem[3007]), 32'h12345);
    chk("t4b_m8", 32'(mem[3008]), 32'd3008);
    chk("t4b_m4000", 32'(mem[4000]), 32'd4000);

    // 5: abort in 3rd WR cycle of a 10-word copy
    launch(1'b0, 14'd200, 14'd5000, 14'd10, 18'h0);
    repeat (5) @(posedge clka);
    #1 abort = 1'b1;
    @(posedge clka);
    #1 abort = 1'b0;
    wait_done("t5");
    chk("t5_cycle", 32'(dcyc), 32'd7);
    chk("t5_err", 32'(derr), 32'd1);
    chk("t5_writes", 32'(wr_n), 32'd3);
    chk("t5_m2", 32'(mem[5002]), 32'd202);
    chk("t5_m3", 32'(mem[5003]), 32'd5003);

    // 6: asynchronous reset during a fill
    launch(1'b1, 14'd0, 14'd6000, 14'd8, 18'h3CCCC);
    repeat (3) @(posedge clka);
    #1 reset = 1'b1;
    #1;
    chk("t6_we_async", 32'(mem_we), 32'd0);
    chk("t6_busy_async", 32'(busy), 32'd0);
    repeat (2) @(negedge clka);
    reset = 1'b0;
    repeat (4) @(negedge clka);
    chk("t6_no_done", 32'(ndone), 32'd0);
    chk("t6_writes", 32'(wr_n), 32'd3);
    chk("t6_m2", 32'(mem[6002]), 32'h3CCCC);
    chk("t6_m3", 32'(mem[6003]), 32'd6003);
    launch(1'b0, 14'd100, 14'd7000, 14'd2, 18'h0);
    wait_done("t6r");
    chk("t6r_cycle", 32'(dcyc), 32'd5);
    chk("t6r_err", 32'(derr), 32'd0);
    chk("t6r_m1", 32'(mem[7001]), 32'd101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
